clm_aes_masked_core: RTL and testbench

// - Iterative AES-128 encryption core (FIPS-197) with a masked ("CLM") datapath.
// - Multiple parallel S-boxes: 16 for the state and 4 for the key schedule.
// - Every internal byte is stored XOR-masked with bytes from random_vect; ciphertext is always plain AES.
// - Sits behind the clm_inouts_if handshake interface; p_det selects the remask round.

---
 rtl/clm_pkg.sv | 55 +++++
 rtl/clm_inouts_if.sv | 20 ++
 rtl/clm_sbox_masked.sv | 13 +
 rtl/clm_aes_masked_core.sv | 156 +++++++++++++++
 tb/tb_clm_aes_masked_core.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clm_pkg.sv
// Shared types, AES constant tables and GF(2^8) helpers for the masked AES core.
package clm_pkg;

  typedef logic [7:0] red_poly_t;
  typedef logic [4:0] p_det_t;

  localparam int NR = 10;

  localparam red_poly_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is unused; rounds 1..10 pick their constant directly by round number.
  localparam red_poly_t RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic red_poly_t sbox(input red_poly_t x);
    return SBOX[x];
  endfunction

  function automatic red_poly_t xtime(input red_poly_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; col = {row0, row1, row2, row3}.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    red_poly_t a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/clm_inouts_if.sv
// Handshake interface between the masked AES core and its host.
interface clm_inouts_if;
  logic         clk;
  logic         rst;
  logic         drdy_i;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         drdy_o;

  modport basic (
    input  clk,
    input  rst,
    input  drdy_i,
    input  plaintext,
    input  key,
    output ciphertext,
    output drdy_o
  );
endinterface

// File: rtl/clm_sbox_masked.sv
// Masked AES S-box: strips the input mask, substitutes, applies a fresh output mask.
module clm_sbox_masked
  import clm_pkg::*;
(
  input  red_poly_t in_m,
  input  red_poly_t m_in,
  input  red_poly_t m_out,
  output red_poly_t out_m
);

  assign out_m = sbox(in_m ^ m_in) ^ m_out;

endmodule

// File: rtl/clm_aes_masked_core.sv
// Iterative masked AES-128 encryption core: one full round per clock.
// Invariant between rounds: r_state_m[i] = state[i] ^ r_m[i] and
// r_key_m[i] = round_key[i] ^ r_m[i]. Byte i maps to row i%4, column i/4.
module clm_aes_masked_core
  import clm_pkg::*;
(
  clm_inouts_if.basic inouts,
  input  p_det_t      p_det,
  input  red_poly_t   random_vect [0:22]
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0] r_fsm;
  logic [3:0] r_rc;
  p_det_t     r_pdet;
  red_poly_t  r_state_m [16];
  red_poly_t  r_key_m   [16];
  red_poly_t  r_m       [16];
  // r_rv[0..3]: key S-box output masks, r_rv[4..6]: remask deltas.
  red_poly_t  r_rv      [7];

  red_poly_t    w_sb_m  [16];
  red_poly_t    w_ks_m  [4];
  red_poly_t    w_sr_m  [16];
  red_poly_t    w_sr_k  [16];
  red_poly_t    w_mc_m  [16];
  red_poly_t    w_mc_k  [16];
  red_poly_t    w_nk_m  [16];
  red_poly_t    w_delta [16];
  red_poly_t    w_ns_m  [16];
  logic [31:0]  w_col_d;
  logic [31:0]  w_col_k;
  logic         w_last;
  logic         w_remask;
  logic [127:0] w_ct;

  // State S-boxes keep each byte under its own mask m[i].
  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox_state
    clm_sbox_masked u_sbox (
      .in_m  (r_state_m[gi]),
      .m_in  (r_m[gi]),
      .m_out (r_m[gi]),
      .out_m (w_sb_m[gi])
    );
  end

  // Key S-boxes take RotWord of the last key word and re-mask with r_rv[j].
  for (genvar gj = 0; gj < 4; gj++) begin : g_sbox_key
    clm_sbox_masked u_sbox (
      .in_m  (r_key_m[12 + ((gj + 1) % 4)]),
      .m_in  (r_m[12 + ((gj + 1) % 4)]),
      .m_out (r_rv[gj]),
      .out_m (w_ks_m[gj])
    );
  end

  // Round datapath: ShiftRows/MixColumns on data and mask in parallel, key expansion, remask.
  always_comb begin
    w_last   = (r_rc == 4'(NR));
    w_remask = ({1'b0, r_rc} == r_pdet);
    w_col_d  = '0;
    w_col_k  = '0;
    w_ct     = '0;

    for (int i = 0; i < 16; i++) begin
      w_sr_m[i] = w_sb_m[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      w_sr_k[i] = r_m[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    end

    for (int c = 0; c < 4; c++) begin
      w_col_d = mix_col({w_sr_m[4*c], w_sr_m[4*c+1], w_sr_m[4*c+2], w_sr_m[4*c+3]});
      w_col_k = mix_col({w_sr_k[4*c], w_sr_k[4*c+1], w_sr_k[4*c+2], w_sr_k[4*c+3]});
      for (int r = 0; r < 4; r++) begin
        w_mc_m[4*c+r] = w_last ? w_sr_m[4*c+r] : w_col_d[31-8*r -: 8];
        w_mc_k[4*c+r] = w_last ? w_sr_k[4*c+r] : w_col_k[31-8*r -: 8];
      end
    end

    // Each new key byte ends up under m[i]; the extra XORs cancel the foreign masks.
    for (int i = 0; i < 4; i++) begin
      w_nk_m[i] = r_key_m[i] ^ w_ks_m[i] ^ r_rv[i] ^ ((i == 0) ? RCON[r_rc] : 8'h00);
    end
    for (int i = 4; i < 16; i++) begin
      w_nk_m[i] = r_key_m[i] ^ w_nk_m[i-4] ^ r_m[i-4];
    end

    for (int i = 0; i < 16; i++) begin
      w_delta[i] = w_remask ? r_rv[4 + (i % 3)] : 8'h00;
      // Mixed mask is swapped for the round-key mask m[i] in the same XOR as AddRoundKey.
      w_ns_m[i]  = w_mc_m[i] ^ w_mc_k[i] ^ w_nk_m[i] ^ w_delta[i];
      w_ct[127-8*i -: 8] = r_state_m[i] ^ r_m[i];
    end
  end

  // Control FSM plus state, key and mask registers.
  always_ff @(posedge inouts.clk) begin
    if (inouts.rst) begin
      r_fsm             <= ST_IDLE;
      r_rc              <= '0;
      r_pdet            <= '0;
      inouts.drdy_o     <= 1'b0;
      inouts.ciphertext <= '0;
      for (int i = 0; i < 16; i++) begin
        r_state_m[i] <= '0;
        r_key_m[i]   <= '0;
        r_m[i]       <= '0;
      end
      for (int j = 0; j < 7; j++) begin
        r_rv[j] <= '0;
      end
    end else begin
      inouts.drdy_o <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (inouts.drdy_i) begin
            for (int i = 0; i < 16; i++) begin
              r_state_m[i] <= inouts.plaintext[127-8*i -: 8] ^ inouts.key[127-8*i -: 8] ^ random_vect[i];
              r_key_m[i]   <= inouts.key[127-8*i -: 8] ^ random_vect[i];
              r_m[i]       <= random_vect[i];
            end
            for (int j = 0; j < 7; j++) begin
              r_rv[j] <= random_vect[16 + j];
            end
            r_pdet <= p_det;
            r_rc   <= 4'd1;
            r_fsm  <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          for (int i = 0; i < 16; i++) begin
            r_state_m[i] <= w_ns_m[i];
            r_key_m[i]   <= w_nk_m[i] ^ w_delta[i];
            r_m[i]       <= r_m[i] ^ w_delta[i];
          end
          if (w_last) begin
            r_fsm <= ST_OUT;
          end else begin
            r_rc <= r_rc + 4'd1;
          end
        end
        ST_OUT: begin
          inouts.ciphertext <= w_ct;
          inouts.drdy_o     <= 1'b1;
          r_fsm             <= ST_IDLE;
        end
        default: begin
          r_fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clm_aes_masked_core.sv
// Self-checking bench for clm_aes_masked_core: reference AES built from GF(2^8)
// arithmetic, a cycle-level acceptance/latency model, and directed scenarios.
module tb_clm_aes_masked_core;
  import clm_pkg::*;

  localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZCT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  clm_inouts_if u_if ();
  p_det_t    p_det;
  red_poly_t random_vect [0:22];

  clm_aes_masked_core u_dut (
    .inouts      (u_if),
    .p_det       (p_det),
    .random_vect (random_vect)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  logic [7:0] sb [256];

  initial begin
    u_if.clk = 1'b0;
    forever #5 u_if.clk = ~u_if.clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a ^= 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sb[s[r + 4*((c + r) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
        for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // Cycle model: accept when idle, result and pulse 11 edges after acceptance.
  int           m_cnt = 0;
  logic [127:0] m_pend = '0;
  logic [127:0] exp_ct = '0;
  logic         exp_vld = 1'b0;
  always @(posedge u_if.clk) begin
    if (u_if.rst) begin
      m_cnt = 0; exp_vld = 1'b0; exp_ct = '0;
    end else begin
      exp_vld = 1'b0;
      if (m_cnt == 1) begin
        exp_ct = m_pend; exp_vld = 1'b1; m_cnt = 0;
      end else if (m_cnt > 1) begin
        m_cnt--;
      end else if (u_if.drdy_i) begin
        m_pend = aes_ref(u_if.key, u_if.plaintext);
        m_cnt = 11;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge u_if.clk) begin
    if (chk_en) begin
      tests++;
      if (u_if.drdy_o !== exp_vld) begin
        fails++;
        $display("FAIL cycle_drdy_o @%0t: got %b want %b", $time, u_if.drdy_o, exp_vld);
      end
      tests++;
      if (u_if.ciphertext !== exp_ct) begin
        fails++;
        $display("FAIL cycle_ciphertext @%0t: got %h want %h", $time, u_if.ciphertext, exp_ct);
      end
    end
  end

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic scramble();
    u_if.key       = {$urandom, $urandom, $urandom, $urandom};
    u_if.plaintext = {$urandom, $urandom, $urandom, $urandom};
    p_det          = 5'($urandom_range(0, 31));
    for (int i = 0; i < 23; i++) random_vect[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic start(input logic [127:0] k, input logic [127:0] p, input logic [4:0] pd,
                       input bit rnd, input logic [7:0] fill, input bit now);
    if (!now) @(negedge u_if.clk);
    u_if.key       = k;
    u_if.plaintext = p;
    p_det          = pd;
    for (int i = 0; i < 23; i++) random_vect[i] = rnd ? 8'($urandom_range(0, 255)) : fill;
    u_if.drdy_i = 1'b1;
    @(negedge u_if.clk);
    u_if.drdy_i = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input string nm, input logic [127:0] want, input bit lit, input int lat);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge u_if.clk);
      n++;
      got = (u_if.drdy_o === 1'b1);
    end
    check({nm, "_latency"}, 128'(n), 128'(lat));
    if (lit) check({nm, "_ct"}, u_if.ciphertext, want);
  endtask

  task automatic no_pulse(input string nm, input int cycles);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(negedge u_if.clk);
      if (u_if.drdy_o === 1'b1) pulses++;
    end
    check({nm, "_pulses"}, 128'(pulses), 128'd0);
  endtask

  initial begin
    build_sbox();
    check("model_c1", aes_ref(C1K, C1P), C1CT);
    check("model_zero", aes_ref('0, '0), ZCT);

    u_if.rst = 1'b1; u_if.drdy_i = 1'b0;
    u_if.key = '0; u_if.plaintext = '0; p_det = '0;
    for (int i = 0; i < 23; i++) random_vect[i] = 8'h00;
    repeat (3) @(negedge u_if.clk);
    chk_en = 1'b1;
    check("reset_ct", u_if.ciphertext, '0);
    check("reset_drdy_o", 128'(u_if.drdy_o), 128'd0);
    u_if.rst = 1'b0;

    start(C1K, C1P, 5'd0, 1'b0, 8'h00, 1'b0);
    wait_done("c1_nomask", C1CT, 1'b1, 11);

    start('0, '0, 5'd15, 1'b0, 8'd109, 1'b0);
    wait_done("zero_mask109", ZCT, 1'b1, 11);

    for (int q = 0; q < 12; q++) begin
      start(C1K, C1P, (q == 11) ? 5'd31 : 5'(q), 1'b1, 8'h00, 1'b0);
      wait_done($sformatf("c1_pdet%0d", (q == 11) ? 31 : q), C1CT, 1'b1, 11);
    end

    // Second start strobe in the middle of a block must be ignored.
    start(C1K, C1P, 5'd3, 1'b1, 8'h00, 1'b0);
    repeat (4) @(negedge u_if.clk);
    u_if.plaintext = 128'hdeadbeef_00000000_cafef00d_12345678;
    u_if.drdy_i = 1'b1;
    @(negedge u_if.clk);
    u_if.drdy_i = 1'b0;
    wait_done("busy_ignore", C1CT, 1'b1, 6);
    no_pulse("busy_ignore_after", 15);

    // Reset around round 5 aborts the block.
    start(C1K, C1P, 5'd7, 1'b1, 8'h00, 1'b0);
    repeat (4) @(negedge u_if.clk);
    u_if.rst = 1'b1;
    @(negedge u_if.clk);
    u_if.rst = 1'b0;
    no_pulse("abort", 15);
    check("abort_ct", u_if.ciphertext, '0);
    start(C1K, C1P, 5'd10, 1'b1, 8'h00, 1'b0);
    wait_done("after_abort", C1CT, 1'b1, 11);

    for (int q = 0; q < 3; q++) begin
      start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            5'($urandom_range(0, 31)), 1'b1, 8'h00, 1'b0);
      wait_done($sformatf("random_blk%0d", q), '0, 1'b0, 11);
    end

    // Back-to-back: strobe raised in the cycle drdy_o pulses.
    start(C1K, C1P, 5'd1, 1'b1, 8'h00, 1'b0);
    wait_done("b2b_first", C1CT, 1'b1, 11);
    start('0, '0, 5'd15, 1'b0, 8'd109, 1'b1);
    wait_done("b2b_second", ZCT, 1'b1, 11);

    repeat (5) @(negedge u_if.clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
